ts_pattern_src: RTL and testbench

TS_PATTERN_SRC -- requirements
Module: ts_pattern_src

---
 rtl/ts_pattern_src.sv | 151 +++++++++++++++
 tb/tb_ts_pattern_src.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_pattern_src.sv
// MPEG-TS test-pattern source: counter / PRBS / constant / null payload, delayed through a
// LAT-deep fs_en-gated pipeline. Define TS_PATTERN_CC_EN to enable the continuity counter.
module ts_pattern_src #(
  parameter int unsigned PKT_LEN = 188,
  parameter int unsigned LAT     = 10
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        fs_en,
  input  logic        ts_rd_head,
  input  logic        ts_rd_vld,
  input  logic [1:0]  mode,
  input  logic [12:0] pid,
  input  logic [7:0]  fill_byte,
  output logic        oe_head,
  output logic        oe,
  output logic [7:0]  symbol_out,
  output logic [15:0] pkt_cnt,
  output logic        short_pkt
);
  typedef enum logic [1:0] {
    M_COUNT = 2'd0,
    M_PRBS  = 2'd1,
    M_CONST = 2'd2,
    M_NULL  = 2'd3
  } mode_e;

  localparam logic [7:0]  LAST_IDX  = 8'(PKT_LEN - 1);
  localparam logic [14:0] LFSR_SEED = 15'h4A80;

  logic [7:0]  r_idx;
  mode_e       r_mode;
  logic [12:0] r_pid;
  logic [7:0]  r_fill;
  logic [14:0] r_lfsr;
  logic [15:0] r_pkt_cnt;
  logic        r_short;

  logic [3:0]  w_cc;
  logic [14:0] w_lfsr_nxt;
  logic [7:0]  w_prbs;
  logic [7:0]  w_sym;
  logic        w_first;
  logic        w_last;
  logic        w_payload;
  logic        w_pkt_done;

  logic        r_pipe_vld  [LAT];
  logic        r_pipe_head [LAT];
  logic [7:0]  r_pipe_sym  [LAT];

  assign w_first    = (r_idx == '0);
  assign w_last     = (r_idx == LAST_IDX);
  assign w_payload  = (r_idx > 8'd3);
  assign w_pkt_done = fs_en && ts_rd_vld && w_last;

  // x^15+x^14+1: each step emits s[14]^s[13] and shifts it in at the LSB; first bit is the byte MSB.
  always_comb begin
    w_lfsr_nxt = r_lfsr;
    w_prbs     = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      w_prbs     = {w_prbs[6:0], w_lfsr_nxt[14] ^ w_lfsr_nxt[13]};
      w_lfsr_nxt = {w_lfsr_nxt[13:0], w_lfsr_nxt[14] ^ w_lfsr_nxt[13]};
    end
  end

  always_comb begin
    w_sym = '0;
    if (ts_rd_vld) begin
      if (w_first) begin
        w_sym = 8'h47;
      end else if (r_idx == 8'd1) begin
        w_sym = (r_mode == M_NULL) ? 8'h5F : {3'b010, r_pid[12:8]};
      end else if (r_idx == 8'd2) begin
        w_sym = (r_mode == M_NULL) ? 8'hFF : r_pid[7:0];
      end else if (r_idx == 8'd3) begin
        w_sym = {4'b0001, w_cc};
      end else begin
        case (r_mode)
          M_COUNT: w_sym = r_idx;
          M_PRBS:  w_sym = w_prbs;
          M_CONST: w_sym = r_fill;
          default: w_sym = 8'hFF;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_mode    <= M_COUNT;
      r_pid     <= '0;
      r_fill    <= '0;
      r_lfsr    <= LFSR_SEED;
      r_pkt_cnt <= '0;
      r_short   <= 1'b0;
    end else if (fs_en) begin
      r_short <= !ts_rd_vld && !w_first;
      if (ts_rd_vld) begin
        r_idx <= w_last ? '0 : r_idx + 8'd1;
        if (w_first) begin
          r_mode <= mode_e'(mode);
          r_pid  <= pid;
          r_fill <= fill_byte;
        end
        if (w_payload && r_mode == M_PRBS) r_lfsr <= w_lfsr_nxt;
        if (w_last) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end else begin
        r_idx <= '0;
      end
    end
  end

`ifdef TS_PATTERN_CC_EN
  logic [3:0] r_cc;
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_cc <= '0;
    else if (w_pkt_done && r_mode != M_NULL) r_cc <= r_cc + 4'd1;
  end
  assign w_cc = r_cc;
`else
  assign w_cc = '0;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        r_pipe_vld[i]  <= 1'b0;
        r_pipe_head[i] <= 1'b0;
        r_pipe_sym[i]  <= '0;
      end
    end else if (fs_en) begin
      r_pipe_vld[0]  <= ts_rd_vld;
      r_pipe_head[0] <= ts_rd_head;
      r_pipe_sym[0]  <= w_sym;
      for (int unsigned i = 1; i < LAT; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_head[i] <= r_pipe_head[i-1];
        r_pipe_sym[i]  <= r_pipe_sym[i-1];
      end
    end
  end

  assign oe         = r_pipe_vld[LAT-1];
  assign oe_head    = r_pipe_head[LAT-1];
  assign symbol_out = r_pipe_sym[LAT-1];
  assign pkt_cnt    = r_pkt_cnt;
  assign short_pkt  = r_short;

endmodule

// File: tb/tb_ts_pattern_src.sv
// Directed bench for ts_pattern_src: each scenario task drives packets and checks the delayed
// stream, pkt_cnt and short_pkt inline against expectations built by the bench.
module tb_ts_pattern_src;
  localparam int unsigned PKT_LEN = 188;
  localparam int unsigned LAT     = 10;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fs_en = 1'b0;
  logic        ts_rd_head = 1'b0;
  logic        ts_rd_vld = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [12:0] pid = '0;
  logic [7:0]  fill_byte = '0;
  logic        oe_head, oe, short_pkt;
  logic [7:0]  symbol_out;
  logic [15:0] pkt_cnt;

  int unsigned checks = 0;
  int unsigned failures = 0;

  logic [9:0]  exp_q [$];
  logic        e_vld, e_head, m_short;
  logic [7:0]  e_sym;
  logic [14:0] m_lfsr;
  logic [3:0]  m_cc;
  logic [15:0] m_pkt;

  ts_pattern_src #(.PKT_LEN(PKT_LEN), .LAT(LAT)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .fs_en(fs_en), .ts_rd_head(ts_rd_head),
    .ts_rd_vld(ts_rd_vld), .mode(mode), .pid(pid), .fill_byte(fill_byte),
    .oe_head(oe_head), .oe(oe), .symbol_out(symbol_out), .pkt_cnt(pkt_cnt),
    .short_pkt(short_pkt)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic string obs();
    return $sformatf("oe=%b head=%b sym=%h cnt=%0d short=%b", oe, oe_head, symbol_out, pkt_cnt, short_pkt);
  endfunction

  function automatic string req();
    return $sformatf("oe=%b head=%b sym=%h cnt=%0d short=%b", e_vld, e_head, e_sym, m_pkt, m_short);
  endfunction

  function automatic logic [7:0] hdr(input int unsigned i, input logic [12:0] p, input logic nul);
    case (i)
      0:       return 8'h47;
      1:       return nul ? 8'h5F : {3'b010, p[12:8]};
      2:       return nul ? 8'hFF : p[7:0];
      default: return {4'h1, m_cc};
    endcase
  endfunction

  task automatic prbs_next(output logic [7:0] b);
    logic fb;
    b = '0;
    for (int k = 0; k < 8; k++) begin
      fb     = m_lfsr[14] ^ m_lfsr[13];
      b      = {b[6:0], fb};
      m_lfsr = {m_lfsr[13:0], fb};
    end
  endtask

  task automatic pkt_done(input logic nul);
    m_pkt = m_pkt + 16'd1;
`ifdef TS_PATTERN_CC_EN
    if (!nul) m_cc = m_cc + 4'd1;
`else
    if (nul) m_cc = m_cc;
`endif
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < int'(LAT) - 1; i++) exp_q.push_back(10'd0);
    m_lfsr = 15'h4A80; m_cc = '0; m_pkt = '0; m_short = 1'b0;
    e_vld = 1'b0; e_head = 1'b0; e_sym = '0;
  endtask

  task automatic cyc(input logic vld, input logic head, input logic [7:0] sym);
    fs_en = 1'b1; ts_rd_vld = vld; ts_rd_head = head;
    exp_q.push_back({vld, head, vld ? sym : 8'h00});
    @(posedge sys_clk); #1;
    {e_vld, e_head, e_sym} = exp_q.pop_front();
  endtask

  task automatic idle();
    fs_en = 1'b0; ts_rd_vld = 1'b0; ts_rd_head = 1'b0;
    @(posedge sys_clk); #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0; #1;
    model_reset();
    checks++;
    if ({oe, oe_head, symbol_out, pkt_cnt, short_pkt} !== 27'd0) begin
      failures++; $display("FAIL reset_async got %s required all zero", obs());
    end
    @(posedge sys_clk); #1;
    checks++;
    if ({oe, oe_head, symbol_out, pkt_cnt, short_pkt} !== 27'd0) begin
      failures++; $display("FAIL reset_hold got %s required all zero", obs());
    end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_counter();
    mode = 2'd0; pid = 13'h100;
    for (int i = 0; i < int'(PKT_LEN + LAT); i++) begin
      logic v; logic [7:0] b;
      v = (i < int'(PKT_LEN));
      b = (i < 4) ? hdr(i, 13'h100, 1'b0) : 8'(i);
      cyc(v, i == 0, b);
      if (i == int'(PKT_LEN) - 1) pkt_done(1'b0);
      checks++;
      if ({oe, oe_head, symbol_out, pkt_cnt, short_pkt} !== {e_vld, e_head, e_sym, m_pkt, m_short}) begin
        failures++; $display("FAIL counter_stream i=%0d got %s required %s", i, obs(), req());
      end
    end
  endtask

  task automatic test_prbs_back_to_back();
    mode = 2'd1; pid = 13'h0AB;
    for (int i = 0; i < int'(2 * PKT_LEN + LAT); i++) begin
      logic v; logic [7:0] b; int j;
      j = i % int'(PKT_LEN);
      v = (i < int'(2 * PKT_LEN));
      b = '0;
      if (v && j < 4) b = hdr(j, 13'h0AB, 1'b0);
      else if (v) prbs_next(b);
      cyc(v, v && j == 0, b);
      if (v && j == int'(PKT_LEN) - 1) pkt_done(1'b0);
      checks++;
      if ({oe, oe_head, symbol_out, pkt_cnt, short_pkt} !== {e_vld, e_head, e_sym, m_pkt, m_short}) begin
        failures++; $display("FAIL prbs_stream i=%0d got %s required %s", i, obs(), req());
      end
    end
  endtask

  task automatic test_short();
    mode = 2'd0; pid = 13'h100;
    for (int i = 0; i < 50 + 1 + 1 + 8 + 1 + int'(LAT); i++) begin
      logic v; int j;
      v = (i < 50) || (i >= 52 && i < 60);
      j = (i < 50) ? i : i - 52;
      m_short = (i == 50) || (i == 60);
      cyc(v, v && j == 0, (j < 4) ? hdr(j, 13'h100, 1'b0) : 8'(j));
      checks++;
      if ({oe, oe_head, symbol_out, pkt_cnt, short_pkt} !== {e_vld, e_head, e_sym, m_pkt, m_short}) begin
        failures++; $display("FAIL short_stream i=%0d got %s required %s", i, obs(), req());
      end
    end
    m_short = 1'b0;
  endtask

  task automatic test_fs_toggle();
    mode = 2'd2; pid = 13'h1234; fill_byte = 8'hA5;
    for (int i = 0; i < int'(PKT_LEN + LAT); i++) begin
      logic v;
      v = (i < int'(PKT_LEN));
      if (i == 30) fill_byte = 8'h00;
      cyc(v, i == 0, (i < 4) ? hdr(i, 13'h1234, 1'b0) : 8'hA5);
      if (i == int'(PKT_LEN) - 1) pkt_done(1'b0);
      checks++;
      if ({oe, oe_head, symbol_out, pkt_cnt, short_pkt} !== {e_vld, e_head, e_sym, m_pkt, m_short}) begin
        failures++; $display("FAIL toggle_stream i=%0d got %s required %s", i, obs(), req());
      end
      idle();
      checks++;
      if ({oe, oe_head, symbol_out, pkt_cnt, short_pkt} !== {e_vld, e_head, e_sym, m_pkt, m_short}) begin
        failures++; $display("FAIL toggle_hold i=%0d got %s required %s", i, obs(), req());
      end
    end
  endtask

  task automatic test_mode_change();
    mode = 2'd0; pid = 13'h100;
    for (int i = 0; i < int'(2 * PKT_LEN + LAT); i++) begin
      logic v; logic nul; logic [7:0] b; int j;
      j = i % int'(PKT_LEN);
      v = (i < int'(2 * PKT_LEN));
      nul = (i >= int'(PKT_LEN));
      if (i == 20) begin mode = 2'd3; pid = 13'h0001; end
      if (j < 4) b = hdr(j, 13'h100, nul);
      else b = nul ? 8'hFF : 8'(j);
      cyc(v, v && j == 0, b);
      if (v && j == int'(PKT_LEN) - 1) pkt_done(nul);
      checks++;
      if ({oe, oe_head, symbol_out, pkt_cnt, short_pkt} !== {e_vld, e_head, e_sym, m_pkt, m_short}) begin
        failures++; $display("FAIL mode_change_stream i=%0d got %s required %s", i, obs(), req());
      end
    end
    mode = 2'd0;
  endtask

  task automatic test_reset_mid();
    mode = 2'd0; pid = 13'h100;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, i == 0, (i < 4) ? hdr(i, 13'h100, 1'b0) : 8'(i));
      if ({oe, oe_head, symbol_out, pkt_cnt, short_pkt} !== {e_vld, e_head, e_sym, m_pkt, m_short}) begin
        failures++; $display("FAIL reset_mid_pre i=%0d got %s required %s", i, obs(), req());
      end
      checks++;
    end
    #3 rst_n = 1'b0; #1;
    checks++;
    if ({oe, oe_head, symbol_out, pkt_cnt, short_pkt} !== 27'd0) begin
      failures++; $display("FAIL reset_mid_async got %s required all zero", obs());
    end
    ts_rd_vld = 1'b0; ts_rd_head = 1'b0;
    @(posedge sys_clk); #3 rst_n = 1'b1;
    model_reset();
    mode = 2'd1; pid = 13'h0AB;
    for (int i = 0; i < int'(PKT_LEN + LAT); i++) begin
      logic v; logic [7:0] b;
      v = (i < int'(PKT_LEN));
      b = '0;
      if (v && i < 4) b = hdr(i, 13'h0AB, 1'b0);
      else if (v) prbs_next(b);
      cyc(v, i == 0, b);
      if (i == int'(PKT_LEN) - 1) pkt_done(1'b0);
      checks++;
      if ({oe, oe_head, symbol_out, pkt_cnt, short_pkt} !== {e_vld, e_head, e_sym, m_pkt, m_short}) begin
        failures++; $display("FAIL reset_mid_stream i=%0d got %s required %s", i, obs(), req());
      end
    end
  endtask

  initial begin
    test_reset();
    test_counter();
    test_prbs_back_to_back();
    test_short();
    test_fs_toggle();
    test_mode_change();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
